// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared definitions for the register file with load scoreboard:
//   XLEN_DEF / NREG_DEF : default data width and register count
//   ZERO_REG            : index of the hardwired-zero register
//   calc_aw()           : address width for a given register count
// Optional feature macro used by the design: REGFILE_BYPASS_EN.
package reg_file_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  // Register count is a power of two (>= 2), so clog2 is exact.
  function automatic int calc_aw(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// One busy bit per register, tracking loads whose data has not returned.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   set_en / set_addr   : mark a register busy (issued load destination)
//   clr_en / clr_addr   : clear a register's busy bit (load writeback)
//   rd_addr (NRD*AW)    : lookup addresses, port i at [i*AW +: AW]
//   rd_busy (NRD)       : registered busy bit of each looked-up register
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = calc_aw(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear is applied before set so a load issued to the same register
  // that is being written back this cycle stays pending. Register 0
  // can never be pending.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (clr_en && (clr_addr == AW'(r)))
        busy_d[r] = 1'b0;
      if (set_en && (set_addr == AW'(r)))
        busy_d[r] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++)
      rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Multi-read-port register file with an ALU writeback port, a memory
// (load) writeback port and a load scoreboard driving a stall signal.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   rd_addr (NRD*AW)             : read addresses, port i at [i*AW +: AW]
//   rd_data (NRD*XLEN)           : read data, port i at [i*XLEN +: XLEN]
//   rd_busy (NRD)                : read source has an outstanding load
//   wa_en / wa_addr / wa_data    : ALU writeback
//   wm_en / wm_addr / wm_data    : memory writeback, also clears busy
//   sb_set_en / sb_set_addr      : mark an issued load's destination busy
//   stall                        : OR of rd_busy
//   wr_conflict                  : one-cycle pulse after both writeback
//                                  ports hit the same nonzero register
// Macro REGFILE_BYPASS_EN: forward same-cycle writeback data and load
// completion to the read ports. Undefined: reads see stored state only.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wm_en,
  input  logic [AW-1:0]       wm_addr,
  input  logic [XLEN-1:0]     wm_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic                stall,
  output logic                wr_conflict
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NRD-1:0]  sb_busy;

  logic wa_write;
  logic wm_write;

  assign wa_write = wa_en && (wa_addr != ZERO_ADDR);
  assign wm_write = wm_en && (wm_addr != ZERO_ADDR);

  // The wm write is issued after the wa write so that, on a same-address
  // collision, the load data is what lands in the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else begin
      if (wa_write)
        regs[wa_addr] <= wa_data;
      if (wm_write)
        regs[wm_addr] <= wm_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wr_conflict <= 1'b0;
    else
      wr_conflict <= wa_write && wm_write && (wa_addr == wm_addr);
  end

  reg_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .clr_en   (wm_en),
    .clr_addr (wm_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            busy;

    assign ra = rd_addr[i*AW +: AW];

    // Outputs are forced to zero while reset is held so that a forwarded
    // write cannot leak out during reset.
    always_comb begin
      data = regs[ra];
      busy = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
      if (ra != ZERO_ADDR) begin
        if (wm_en && (wm_addr == ra)) begin
          data = wm_data;
          if (!(sb_set_en && (sb_set_addr == ra)))
            busy = 1'b0;
        end else if (wa_en && (wa_addr == ra)) begin
          data = wa_data;
        end
      end
`endif
      if (!reset) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy;
  end

  assign stall = |rd_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Self-checking bench for reg_file_sb. The default build (XLEN=32,
// NREG=32, NRD=2) is driven with directed sequences and random traffic
// against a behavioural model; a second NRD=4/XLEN=64/NREG=16 instance
// checks wide multi-port reads. Honours REGFILE_BYPASS_EN in its model.
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wm_en;
  logic [4:0]  wm_addr;
  logic [31:0] wm_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        stall;
  logic        wr_conflict;

  logic         q_reset;
  logic [15:0]  q_rd_addr;
  logic [255:0] q_rd_data;
  logic [3:0]   q_rd_busy;
  logic         q_wa_en;
  logic [3:0]   q_wa_addr;
  logic [63:0]  q_wa_data;
  logic         q_stall;
  logic         q_wr_conflict;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] mRegs [32];
  logic        mBusy [32];
  logic        mConflict;

  reg_file_sb dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wm_en       (wm_en),
    .wm_addr     (wm_addr),
    .wm_data     (wm_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .stall       (stall),
    .wr_conflict (wr_conflict)
  );

  reg_file_sb #(
    .XLEN (64),
    .NREG (16),
    .NRD  (4)
  ) dut_wide (
    .clk         (clk),
    .reset       (q_reset),
    .rd_addr     (q_rd_addr),
    .rd_data     (q_rd_data),
    .rd_busy     (q_rd_busy),
    .wa_en       (q_wa_en),
    .wa_addr     (q_wa_addr),
    .wa_data     (q_wa_data),
    .wm_en       (1'b0),
    .wm_addr     (4'd0),
    .wm_data     (64'd0),
    .sb_set_en   (1'b0),
    .sb_set_addr (4'd0),
    .stall       (q_stall),
    .wr_conflict (q_wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector, reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int r = 0; r < 32; r++) begin
      mRegs[r] = '0;
      mBusy[r] = 1'b0;
    end
    mConflict = 1'b0;
  endtask

  // Expected read value for the current inputs and stored model state.
  function automatic logic [31:0] expRead(input logic [4:0] a);
    logic [31:0] v;
    if (!reset) return '0;
    v = mRegs[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      if (wm_en && wm_addr == a) v = wm_data;
      else if (wa_en && wa_addr == a) v = wa_data;
    end
`endif
    return v;
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    logic b;
    if (!reset) return 1'b0;
    b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && wm_en && wm_addr == a && !(sb_set_en && sb_set_addr == a))
      b = 1'b0;
`endif
    return b;
  endfunction

  // Architectural effect of one rising edge.
  task automatic updateModel();
    if (!reset) begin
      clearModel();
    end else begin
      mConflict = wa_en && wm_en && (wa_addr == wm_addr) && (wa_addr != 0);
      if (wa_en && wa_addr != 0) mRegs[wa_addr] = wa_data;
      if (wm_en && wm_addr != 0) mRegs[wm_addr] = wm_data;
      if (wm_en) mBusy[wm_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) mBusy[sb_set_addr] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                               input logic wme, input logic [4:0] wma, input logic [31:0] wmd,
                               input logic se, input logic [4:0] sa,
                               input logic [4:0] r0, input logic [4:0] r1);
    reset       = rst;
    wa_en       = wae;
    wa_addr     = waa;
    wa_data     = wad;
    wm_en       = wme;
    wm_addr     = wma;
    wm_data     = wmd;
    sb_set_en   = se;
    sb_set_addr = sa;
    rd_addr     = {r1, r0};
    if (!rst) clearModel();
  endtask

  // Check all outputs against the model mid-cycle, then advance one edge.
  task automatic stepCycle();
    logic b0, b1;
    @(negedge clk);
    b0 = expBusy(rd_addr[4:0]);
    b1 = expBusy(rd_addr[9:5]);
    checkOutput("rd_data0", 64'(rd_data[31:0]), 64'(expRead(rd_addr[4:0])));
    checkOutput("rd_data1", 64'(rd_data[63:32]), 64'(expRead(rd_addr[9:5])));
    checkOutput("rd_busy0", 64'(rd_busy[0]), 64'(b0));
    checkOutput("rd_busy1", 64'(rd_busy[1]), 64'(b1));
    checkOutput("stall", 64'(stall), 64'(b0 | b1));
    checkOutput("wr_conflict", 64'(wr_conflict), 64'(mConflict));
    @(posedge clk);
    updateModel();
    #1;
  endtask

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  logic [63:0] widePat [4];

  initial begin
    widePat[0] = 64'h0123_4567_89AB_CDEF;
    widePat[1] = 64'hFEDC_BA98_7654_3210;
    widePat[2] = 64'h8000_0000_0000_0001;
    widePat[3] = 64'hDEAD_BEEF_CAFE_F00D;

    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q_reset   = 1'b0;
    q_rd_addr = '0;
    q_wa_en   = 1'b0;
    q_wa_addr = '0;
    q_wa_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Wide build: four ports reading registers 1..4.
    q_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      q_wa_en   = 1'b1;
      q_wa_addr = 4'(k + 1);
      q_wa_data = widePat[k];
      @(posedge clk);
      #1;
    end
    q_wa_en   = 1'b0;
    q_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("wide_rd%0d", k), q_rd_data[k*64 +: 64], widePat[k]);
    checkOutput("wide_stall", 64'(q_stall), 64'd0);
    @(posedge clk);
    #1;

    // Reset state of the default build.
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Write then read back, then asynchronous reset clears it at once.
    applyStimulus(1'b1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1 checkOutput("req31_rd", 64'(rd_data[31:0]), 64'hDEADBEEF);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1 checkOutput("req31_rst", 64'(rd_data[31:0]), 64'd0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    stepCycle();

    // Register 0 ignores writes and scoreboard sets.
    applyStimulus(1'b1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("req32_rd0", 64'(rd_data[31:0]), 64'd0);
    checkOutput("req32_busy0", 64'(rd_busy[0]), 64'd0);
    stepCycle();

    // Load pending on 7, then completed by the memory port.
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    #1 checkOutput("req33_busy", 64'(rd_busy[0]), 64'd1);
    checkOutput("req33_stall", 64'(stall), 64'd1);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    #1 checkOutput("req33_rd", 64'(rd_data[31:0]), 64'h1234);
    checkOutput("req33_clr", 64'(rd_busy[0]), 64'd0);
    stepCycle();

    // Both writeback ports on register 3.
    applyStimulus(1'b1, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    #1 checkOutput("req34_rd", 64'(rd_data[31:0]), 64'h22);
    checkOutput("req34_conf", 64'(wr_conflict), 64'd1);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    #1 checkOutput("req34_pulse", 64'(wr_conflict), 64'd0);
    stepCycle();

    // Set and clear of register 9 in the same cycle: set wins.
    applyStimulus(1'b1, 0, 0, 0, 1, 9, 32'h55, 1, 9, 0, 0);
    stepCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    #1 checkOutput("req35_busy", 64'(rd_busy[1]), 64'd1);
    checkOutput("req35_stall", 64'(stall), 64'd1);
    stepCycle();

    // Random traffic biased toward a few registers to provoke collisions.
    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    1'($urandom_range(0, 1)), randAddr(),
                    randAddr(), randAddr());
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
